store_buffer: RTL and testbench

- Sits directly downstream of the single-cycle core's data-memory port; consumes MemWrite, ALUResult (address) and WriteData, and produces ReadData.
- Decouples core stores from a slower backing data memory whose write port uses a valid/ready handshake.
- Queues up to DEPTH word stores in a circular FIFO and drains them in order.
- Forwards the youngest matching queued store to loads so the core always sees memory-consistent ReadData.

---
 rtl/store_buffer_if.sv | 29 ++
 rtl/store_buffer.sv | 87 ++++++++
 tb/tb_store_buffer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Backing data-memory port: async read path plus valid/ready write path.
// Latency: none, signal bundle only.
// Backpressure: mem_wready from the memory side holds the write presented by the master.
interface store_buffer_if;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wvalid;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wready;

  modport master (
    output mem_raddr,
    input  mem_rdata,
    output mem_wvalid,
    output mem_waddr,
    output mem_wdata,
    input  mem_wready
  );

  modport slave (
    input  mem_raddr,
    output mem_rdata,
    input  mem_wvalid,
    input  mem_waddr,
    input  mem_wdata,
    output mem_wready
  );
endinterface

// File: rtl/store_buffer.sv
// Store FIFO between the core data port and a slow memory, with youngest-match load forwarding.
// Latency: push to mem_wvalid 1 cycle; ReadData combinational.
// Backpressure: Stall = MemWrite & full (independent of mem_wready); head held until mem_wready.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           MemWrite,
  input  logic [31:0]    ALUResult,
  input  logic [31:0]    WriteData,
  output logic [31:0]    ReadData,
  output logic           Stall,
  output logic           Empty,
  output logic [PTRW:0]  Count,
  store_buffer_if.master mem
);

  logic [31:0]      ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PTRW-1:0]  head;
  logic [PTRW-1:0]  tail;
  logic [PTRW-1:0]  idx;
  logic [PTRW:0]    count_q;
  logic             full;
  logic             push;
  logic             pop;

  assign full  = (count_q == (PTRW+1)'(DEPTH));
  assign Empty = (count_q == '0);
  assign Count = count_q;
  assign Stall = MemWrite & full;
  assign push  = MemWrite & ~full;
  assign pop   = ~Empty & mem.mem_wready;

  assign mem.mem_raddr  = ALUResult;
  assign mem.mem_wvalid = ~Empty;
  assign mem.mem_waddr  = ent_addr[head];
  assign mem.mem_wdata  = ent_data[head];

  // Pointers, occupancy and valid bits; push and pop never target the same slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        head          <= head + 1'b1;
        ent_vld[head] <= 1'b0;
      end
      if (push) begin
        tail          <= tail + 1'b1;
        ent_vld[tail] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload capture; storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= ALUResult;
      ent_data[tail] <= WriteData;
    end
  end

  // Forwarding: walk oldest to youngest from head so the youngest match wins.
  always_comb begin
    ReadData = mem.mem_rdata;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTRW'(i);
      if (ent_vld[idx] && (ent_addr[idx][31:2] == ALUResult[31:2])) begin
        ReadData = ent_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed plan steps then random traffic against a queue model.
// Latency: checks combinational outputs 1 time unit after inputs change, model steps at posedge.
// Backpressure: mem_wready driven directly or randomly by the bench.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int PTRW  = 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWrite;
  logic [31:0]   ALUResult;
  logic [31:0]   WriteData;
  logic [31:0]   ReadData;
  logic          Stall;
  logic          Empty;
  logic [PTRW:0] Count;

  int n_checks = 0;
  int n_fails  = 0;
  st_t q[$];

  store_buffer_if mif ();

  store_buffer #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Empty     (Empty),
    .Count     (Count),
    .mem       (mif.master)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check outputs against the queue model, advance model at the edge.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                      input logic wr, input logic [31:0] rd);
    logic [31:0] exp_rd;
    bit do_push;
    bit do_pop;
    MemWrite = mw;
    ALUResult = a;
    WriteData = d;
    mif.mem_wready = wr;
    mif.mem_rdata = rd;
    #1;
    exp_rd = rd;
    foreach (q[i]) if (q[i].a[31:2] == a[31:2]) exp_rd = q[i].d;
    chk("count", 32'(Count), 32'(q.size()));
    chk("empty", 32'(Empty), 32'(q.size() == 0));
    chk("stall", 32'(Stall), 32'(mw && q.size() == DEPTH));
    chk("wvalid", 32'(mif.mem_wvalid), 32'(q.size() != 0));
    chk("raddr", mif.mem_raddr, a);
    chk("rdata", ReadData, exp_rd);
    if (q.size() != 0) begin
      chk("waddr", mif.mem_waddr, q[0].a);
      chk("wdata", mif.mem_wdata, q[0].d);
    end
    do_pop  = (q.size() != 0) && wr;
    do_push = mw && (q.size() < DEPTH);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{a: a, d: d});
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    MemWrite = 1'b0;
    ALUResult = '0;
    WriteData = '0;
    mif.mem_wready = 1'b0;
    mif.mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_empty", 32'(Empty), 32'd1);
    chk("rst_wvalid", 32'(mif.mem_wvalid), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Idle: ReadData follows memory.
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF);
    chk("idle_rdata", ReadData, 32'hDEADBEEF);

    // Single store then load hits the buffer.
    step(1'b1, 32'h40, 32'h11111111, 1'b0, 32'h0);
    step(1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
    chk("fwd_single", ReadData, 32'h11111111);
    step(1'b0, 32'h40, 32'h0, 1'b1, 32'h0);

    // Two stores to one address: youngest forwarded, both drained in order.
    step(1'b1, 32'h80, 32'hA, 1'b0, 32'h0);
    step(1'b1, 32'h80, 32'hB, 1'b0, 32'h0);
    step(1'b0, 32'h82, 32'h0, 1'b0, 32'h5);
    chk("fwd_youngest", ReadData, 32'hB);
    step(1'b0, 32'h80, 32'h0, 1'b1, 32'h0);
    step(1'b0, 32'h80, 32'h0, 1'b1, 32'h0);
    step(1'b0, 32'h80, 32'h0, 1'b0, 32'h77);

    // Fill to DEPTH, stall the fifth, free one slot, fifth goes in.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h200 + 32'(i) * 4, 32'h1000 + 32'(i), 1'b0, 32'h0);
    step(1'b1, 32'h300, 32'h5555, 1'b0, 32'h0);
    chk("full_stall", 32'(Stall), 32'd1);
    step(1'b1, 32'h300, 32'h5555, 1'b1, 32'h0);
    chk("after_pop_count", 32'(Count), 32'd3);
    step(1'b1, 32'h300, 32'h5555, 1'b0, 32'h0);
    chk("fifth_in_count", 32'(Count), 32'd4);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

    // Streaming push+pop with pointer wrap.
    for (int i = 0; i < 10; i++) step(1'b1, 32'h400 + 32'(i) * 4, 32'h2000 + 32'(i), 1'b1, 32'h0);
    chk("stream_count", 32'(Count), 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

    // Async reset mid-drain with three queued stores.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 32'(i) * 4, 32'h3000 + 32'(i), 1'b0, 32'h0);
    MemWrite = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", 32'(Count), 32'd0);
    chk("arst_wvalid", 32'(mif.mem_wvalid), 32'd0);
    chk("arst_empty", 32'(Empty), 32'd1);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 32'h604, 32'h0, 1'b0, 32'h12345678);
    chk("post_rst_rdata", ReadData, 32'h12345678);

    // Random traffic over a small address window so forwarding hits often.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)),
           32'h100 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3)),
           $urandom, 1'($urandom_range(0, 2) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
